// File: rtl/tof_trig_timer.sv
// Time-of-flight trigger timer: fires a masked trigger pulse, then timestamps the first
// echo edge on each input channel until all channels have hit or the timeout is reached.
//
// state  | meaning
// IDLE   | waiting for io_start; results of last measurement held
// FIRE   | trigger pulse driven, counter running, echoes captured
// WAIT   | pulse finished, counter running, echoes captured
module tof_trig_timer #(
  parameter int N_OUT   = 3,
  parameter int N_IN    = 2,
  parameter int CNT_W   = 16,
  parameter int PULSE_W = 4
) (
  input  logic                  io_mainClk,
  input  logic                  io_asyncReset,
  input  logic                  io_start,
  input  logic [N_OUT-1:0]      io_outMask,
  input  logic [PULSE_W-1:0]    io_pulseLen,
  input  logic [CNT_W-1:0]      io_timeout,
  input  logic [N_IN-1:0]       io_trigsIn,
  output logic [N_OUT-1:0]      io_trigsOut,
  output logic                  io_busy,
  output logic                  io_done,
  output logic                  io_timedOut,
  output logic [N_IN-1:0]       io_hitMask,
  output logic [N_IN*CNT_W-1:0] io_stamps
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FIRE = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t               state_q, state_d;
  logic [PULSE_W-1:0]   plen_q, plen_d;
  logic [CNT_W-1:0]     tmo_q, tmo_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [N_OUT-1:0]     trig_q, trig_d;
  logic                 done_q, done_d;
  logic                 tout_q, tout_d;
  logic [N_IN-1:0]      hit_q, hit_d;
  logic [N_IN*CNT_W-1:0] stamps_q, stamps_d;

  logic [N_IN-1:0]      sync1_q, sync2_q, prev_q;
  logic [N_IN-1:0]      edge_det;
  logic [N_IN-1:0]      new_hit;
  logic                 active;
  logic                 hit_all;
  logic                 tmo_hit;
  logic                 term;
  logic                 pulse_last;

  // Echo synchroniser runs in every state so edges are clean the moment a measurement starts.
  always_ff @(posedge io_mainClk or posedge io_asyncReset) begin
    if (io_asyncReset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= io_trigsIn;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign edge_det   = sync2_q & ~prev_q;
  assign active     = (state_q != S_IDLE);
  assign new_hit    = active ? (edge_det & ~hit_q) : '0;
  assign hit_all    = &(hit_q | new_hit);
  assign tmo_hit    = (cnt_q == tmo_q);
  assign term       = active && (hit_all || tmo_hit);
  assign pulse_last = (cnt_q == (CNT_W'(plen_q) - CNT_ONE));

  always_ff @(posedge io_mainClk or posedge io_asyncReset) begin
    if (io_asyncReset) begin
      state_q  <= S_IDLE;
      plen_q   <= '0;
      tmo_q    <= '0;
      cnt_q    <= '0;
      trig_q   <= '0;
      done_q   <= 1'b0;
      tout_q   <= 1'b0;
      hit_q    <= '0;
      stamps_q <= '0;
    end else begin
      state_q  <= state_d;
      plen_q   <= plen_d;
      tmo_q    <= tmo_d;
      cnt_q    <= cnt_d;
      trig_q   <= trig_d;
      done_q   <= done_d;
      tout_q   <= tout_d;
      hit_q    <= hit_d;
      stamps_q <= stamps_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    plen_d   = plen_q;
    tmo_d    = tmo_q;
    cnt_d    = cnt_q;
    trig_d   = trig_q;
    done_d   = 1'b0;
    tout_d   = tout_q;
    hit_d    = hit_q;
    stamps_d = stamps_q;

    case (state_q)
      S_IDLE: begin
        if (io_start) begin
          state_d  = S_FIRE;
          plen_d   = (io_pulseLen == '0) ? PULSE_W'(1) : io_pulseLen;
          tmo_d    = io_timeout;
          cnt_d    = '0;
          trig_d   = io_outMask;
          tout_d   = 1'b0;
          hit_d    = '0;
          stamps_d = '0;
        end
      end

      S_FIRE, S_WAIT: begin
        for (int i = 0; i < N_IN; i++) begin
          if (new_hit[i]) begin
            hit_d[i]                  = 1'b1;
            stamps_d[i*CNT_W +: CNT_W] = cnt_q;
          end
        end
        if (term) begin
          // Reaching here without every channel hit means the timeout ended it.
          state_d = S_IDLE;
          trig_d  = '0;
          done_d  = 1'b1;
          tout_d  = ~hit_all;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
          if ((state_q == S_FIRE) && pulse_last) begin
            state_d = S_WAIT;
            trig_d  = '0;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        trig_d  = '0;
      end
    endcase
  end

  assign io_trigsOut = trig_q;
  assign io_busy     = active;
  assign io_done     = done_q;
  assign io_timedOut = tout_q;
  assign io_hitMask  = hit_q;
  assign io_stamps   = stamps_q;

endmodule

// File: tb/tb_tof_trig_timer.sv
// Bench for tof_trig_timer: directed scenarios plus randomized measurements checked
// against an arithmetic model of termination time, hits, stamps and pulse length.
module tb_tof_trig_timer;
  localparam int N_OUT   = 3;
  localparam int N_IN    = 2;
  localparam int CNT_W   = 16;
  localparam int PULSE_W = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   start;
  logic [N_OUT-1:0]       mask;
  logic [PULSE_W-1:0]     plen;
  logic [CNT_W-1:0]       tmo;
  logic [N_IN-1:0]        tb_in;
  logic                   loop_en;
  logic [N_IN-1:0]        trigs_in;
  logic [N_OUT-1:0]       trigs_out;
  logic                   busy, done, timed_out;
  logic [N_IN-1:0]        hit_mask;
  logic [N_IN*CNT_W-1:0]  stamps;

  int n_cmp = 0;
  int n_err = 0;

  // Echo schedule for run_meas: cycle index (counter value) at which the input rises, -1 = never.
  int e_at  [N_IN];
  bit e_dbl [N_IN];

  assign trigs_in = loop_en ? trigs_out[N_IN-1:0] : tb_in;

  always #5 clk = ~clk;

  tof_trig_timer #(
    .N_OUT(N_OUT), .N_IN(N_IN), .CNT_W(CNT_W), .PULSE_W(PULSE_W)
  ) dut (
    .io_mainClk   (clk),
    .io_asyncReset(rst),
    .io_start     (start),
    .io_outMask   (mask),
    .io_pulseLen  (plen),
    .io_timeout   (tmo),
    .io_trigsIn   (trigs_in),
    .io_trigsOut  (trigs_out),
    .io_busy      (busy),
    .io_done      (done),
    .io_timedOut  (timed_out),
    .io_hitMask   (hit_mask),
    .io_stamps    (stamps)
  );

  // One measurement: start, then cycle-by-cycle checks against the model.
  task automatic run_meas(input string name, input logic [N_OUT-1:0] m, input int p,
                          input int t, input bit lp);
    int d [N_IN];
    bit has [N_IN];
    int term_c, mx, hi, pe;
    bit allh;
    logic [N_IN-1:0]       exp_hit;
    logic [N_IN*CNT_W-1:0] exp_st;
    logic                  exp_to;
    logic [N_OUT-1:0]      exp_trig;

    // An echo rising in counter cycle k is seen by the timer when the counter reads k+2.
    for (int i = 0; i < N_IN; i++) begin
      if (lp) begin
        has[i] = m[i];
        d[i]   = 2;
      end else begin
        has[i] = (e_at[i] >= 0);
        d[i]   = e_at[i] + 2;
      end
    end
    allh = 1'b1;
    mx   = 0;
    for (int i = 0; i < N_IN; i++) begin
      if (!has[i]) allh = 1'b0;
      else if (d[i] > mx) mx = d[i];
    end
    term_c = t;
    if (allh && mx < term_c) term_c = mx;
    exp_hit = '0;
    exp_st  = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (has[i] && d[i] <= term_c) begin
        exp_hit[i]                = 1'b1;
        exp_st[i*CNT_W +: CNT_W]  = CNT_W'(d[i]);
      end
    end
    exp_to = (exp_hit != {N_IN{1'b1}});
    pe = (p == 0) ? 1 : p;
    hi = (pe < term_c + 1) ? pe : term_c + 1;

    tb_in   = '0;
    loop_en = lp;
    @(posedge clk); #1;
    start = 1'b1; mask = m; plen = PULSE_W'(p); tmo = CNT_W'(t);
    @(posedge clk); #1;
    start = 1'b0;
    mask  = N_OUT'($urandom);
    plen  = PULSE_W'($urandom);
    tmo   = CNT_W'($urandom_range(0, 3));

    for (int k = 0; k <= term_c + 2; k++) begin
      if (!lp) begin
        for (int i = 0; i < N_IN; i++) begin
          if (e_at[i] >= 0 && e_at[i] == k) tb_in[i] = 1'b1;
          if (e_at[i] >= 0 && e_dbl[i] && e_at[i] + 1 == k) tb_in[i] = 1'b0;
          if (e_at[i] >= 0 && e_dbl[i] && e_at[i] + 3 == k) tb_in[i] = 1'b1;
        end
      end
      if (term_c >= 2 && k == 1) start = 1'b1;
      if (k == 2) start = 1'b0;
      @(negedge clk);
      exp_trig = (k < hi) ? m : '0;
      n_cmp++;
      if (trigs_out !== exp_trig) begin
        n_err++;
        $display("FAIL %s trigsOut cycle %0d: got %b want %b", name, k, trigs_out, exp_trig);
      end
      n_cmp++;
      if (busy !== (k <= term_c)) begin
        n_err++;
        $display("FAIL %s busy cycle %0d: got %b want %b", name, k, busy, (k <= term_c));
      end
      n_cmp++;
      if (done !== (k == term_c + 1)) begin
        n_err++;
        $display("FAIL %s done cycle %0d: got %b want %b", name, k, done, (k == term_c + 1));
      end
      if (k >= term_c + 1) begin
        n_cmp++;
        if (hit_mask !== exp_hit) begin
          n_err++;
          $display("FAIL %s hitMask cycle %0d: got %b want %b", name, k, hit_mask, exp_hit);
        end
        n_cmp++;
        if (stamps !== exp_st) begin
          n_err++;
          $display("FAIL %s stamps cycle %0d: got %h want %h", name, k, stamps, exp_st);
        end
        n_cmp++;
        if (timed_out !== exp_to) begin
          n_err++;
          $display("FAIL %s timedOut cycle %0d: got %b want %b", name, k, timed_out, exp_to);
        end
      end
      @(posedge clk); #1;
    end

    tb_in   = '0;
    loop_en = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (hit_mask !== exp_hit || stamps !== exp_st || timed_out !== exp_to) begin
      n_err++;
      $display("FAIL %s results held in idle: got %b/%h/%b want %b/%h/%b", name,
               hit_mask, stamps, timed_out, exp_hit, exp_st, exp_to);
    end
  endtask

  task automatic clear_echoes();
    for (int i = 0; i < N_IN; i++) begin
      e_at[i]  = -1;
      e_dbl[i] = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; mask = '0; plen = '0; tmo = '0; tb_in = '0; loop_en = 1'b0;
    #1;
    n_cmp++;
    if (trigs_out !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL reset ctrl: got trig=%b busy=%b done=%b want 0/0/0", trigs_out, busy, done);
    end
    n_cmp++;
    if (timed_out !== 1'b0 || hit_mask !== '0 || stamps !== '0) begin
      n_err++;
      $display("FAIL reset results: got %b/%b/%h want 0", timed_out, hit_mask, stamps);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_loopback();
    clear_echoes();
    run_meas("loopback", 3'b011, 4, 100, 1'b1);
  endtask

  task automatic test_timeout();
    clear_echoes();
    run_meas("timeout", 3'b111, 3, 10, 1'b0);
  endtask

  task automatic test_single_echo();
    clear_echoes();
    e_at[0]  = 3;
    e_dbl[0] = 1'b1;
    run_meas("single_echo", 3'b001, 2, 20, 1'b0);
  endtask

  task automatic test_truncate();
    clear_echoes();
    e_at[1] = 4;
    run_meas("truncate", 3'b101, 15, 6, 1'b0);
  endtask

  task automatic test_tie();
    clear_echoes();
    run_meas("tie_allhit_timeout", 3'b011, 1, 2, 1'b1);
  endtask

  task automatic test_back_to_back();
    tb_in = '0; loop_en = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; mask = 3'b110; plen = 4'd5; tmo = '0;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (trigs_out !== 3'b110 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL b2b tmo0 fire: got trig=%b busy=%b want 110/1", trigs_out, busy);
    end
    @(posedge clk); #1;
    start = 1'b1; mask = 3'b001; plen = 4'd2; tmo = 16'd3;
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0 || trigs_out !== '0) begin
      n_err++;
      $display("FAIL b2b tmo0 done: got done=%b busy=%b trig=%b want 1/0/000", done, busy, trigs_out);
    end
    n_cmp++;
    if (timed_out !== 1'b1 || hit_mask !== '0 || stamps !== '0) begin
      n_err++;
      $display("FAIL b2b tmo0 results: got %b/%b/%h want 1/00/0", timed_out, hit_mask, stamps);
    end
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      n_cmp++;
      if (busy !== (k <= 3) || done !== (k == 4) || trigs_out !== ((k < 2) ? 3'b001 : 3'b000)) begin
        n_err++;
        $display("FAIL b2b second cycle %0d: got busy=%b done=%b trig=%b", k, busy, done, trigs_out);
      end
      if (k == 0) begin
        n_cmp++;
        if (timed_out !== 1'b0) begin
          n_err++;
          $display("FAIL b2b timedOut cleared on accept: got %b want 0", timed_out);
        end
      end
      @(posedge clk); #1;
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic test_abort();
    tb_in = '0; loop_en = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; mask = 3'b011; plen = 4'd2; tmo = 16'd50;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k <= 6; k++) begin
      if (k == 1) tb_in[0] = 1'b1;
      if (k == 2) start = 1'b1;
      if (k == 3) start = 1'b0;
      if (k < 6) begin
        @(posedge clk); #1;
      end
    end
    @(negedge clk);
    n_cmp++;
    if (hit_mask !== 2'b01 || stamps[CNT_W-1:0] !== 16'd3 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL abort pre-reset: got hit=%b stamp0=%0d busy=%b want 01/3/1",
               hit_mask, stamps[CNT_W-1:0], busy);
    end
    #2;
    rst = 1'b1; tb_in = '0;
    #1;
    n_cmp++;
    if (trigs_out !== '0 || busy !== 1'b0 || done !== 1'b0 || timed_out !== 1'b0 ||
        hit_mask !== '0 || stamps !== '0) begin
      n_err++;
      $display("FAIL abort instant clear: got trig=%b busy=%b done=%b to=%b hit=%b st=%h",
               trigs_out, busy, done, timed_out, hit_mask, stamps);
    end
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL abort after release cycle %0d: got done=%b busy=%b want 0/0", k, done, busy);
      end
    end
    clear_echoes();
    run_meas("after_abort", 3'b011, 4, 100, 1'b1);
  endtask

  task automatic test_random();
    logic [N_OUT-1:0] m;
    int p, t;
    bit lp;
    for (int n = 0; n < 40; n++) begin
      m  = N_OUT'($urandom_range(0, 7));
      p  = $urandom_range(0, 15);
      t  = $urandom_range(0, 30);
      lp = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < N_IN; i++) begin
        e_at[i]  = ($urandom_range(0, 3) == 0) ? -1 : $urandom_range(0, 30);
        e_dbl[i] = bit'($urandom_range(0, 1));
      end
      run_meas($sformatf("random%0d", n), m, p, t, lp);
    end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_timeout();
    test_single_echo();
    test_truncate();
    test_tie();
    test_back_to_back();
    test_abort();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
